// File: rtl/frecuencimetro.sv
// frecuencimetro: counts rising edges of an asynchronous input over a fixed gate window
// and shows the latched count in Hz on six active-low 7-segment displays.
module frecuencimetro #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int GATE_CYCLES = CLK_FREQ,
    parameter int MAX_COUNT   = 999_999
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       signal,
    output logic [6:0] disp0,
    output logic [6:0] disp1,
    output logic [6:0] disp2,
    output logic [6:0] disp3,
    output logic [6:0] disp4,
    output logic [6:0] disp5
);
    localparam int GW = $clog2(GATE_CYCLES + 1);
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [19:0] MAX = 20'(MAX_COUNT);

    logic          sync1, sync2, prev;
    logic          pulse, window_end;
    logic [GW-1:0] gate;
    logic [19:0]   edge_count, result, closing;
    logic [23:0]   bcd;

    function automatic logic [23:0] to_bcd(input logic [19:0] bin);
        logic [43:0] s;
        s = {24'd0, bin};
        for (int i = 0; i < 20; i++) begin
            for (int d = 0; d < 6; d++)
                if (s[20+4*d +: 4] > 4'd4) s[20+4*d +: 4] = s[20+4*d +: 4] + 4'd3;
            s = s << 1;
        end
        return s[43:20];
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    assign pulse      = sync2 & ~prev;
    assign window_end = gate == GATE_LAST;
    // Saturating count including this cycle's pulse; feeds both the counter and the latch
    // so an edge on the window-end cycle lands in the closing window exactly once.
    assign closing    = (pulse && edge_count < MAX) ? edge_count + 20'd1 : edge_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            prev       <= 1'b0;
            gate       <= '0;
            edge_count <= '0;
            result     <= '0;
        end else begin
            sync1      <= signal;
            sync2      <= sync1;
            prev       <= sync2;
            gate       <= window_end ? '0 : gate + 1'b1;
            edge_count <= window_end ? '0 : closing;
            if (window_end) result <= closing;
        end
    end

    always_comb bcd = to_bcd(result);

    assign disp0 = seg7(bcd[3:0]);
    assign disp1 = seg7(bcd[7:4]);
    assign disp2 = seg7(bcd[11:8]);
    assign disp3 = seg7(bcd[15:12]);
    assign disp4 = seg7(bcd[19:16]);
    assign disp5 = seg7(bcd[23:20]);
endmodule

// File: tb/tb_frecuencimetro.sv
// tb_frecuencimetro: two meters (one with a low saturation limit) driven with random and
// directed waveforms, checked against per-window edge tallies kept by the bench.
module tb_frecuencimetro;
    localparam int GA = 2400;
    localparam int GB = 1200;
    localparam int MAX_A = 999_999;
    localparam int MAX_B = 500;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sig_a = 1'b0, sig_b = 1'b0;
    logic [6:0] a0, a1, a2, a3, a4, a5, b0, b1, b2, b3, b4, b5;
    logic [41:0] disp_a, disp_b;
    int n_cmp = 0, n_fail = 0;
    int cyc = 0;
    int ca[int];
    int cb[int];

    always #10 clk = ~clk;

    frecuencimetro #(.GATE_CYCLES(GA)) dut_a (
        .clk(clk), .rst(rst), .signal(sig_a),
        .disp0(a0), .disp1(a1), .disp2(a2), .disp3(a3), .disp4(a4), .disp5(a5));
    frecuencimetro #(.GATE_CYCLES(GB), .MAX_COUNT(MAX_B)) dut_b (
        .clk(clk), .rst(rst), .signal(sig_b),
        .disp0(b0), .disp1(b1), .disp2(b2), .disp3(b3), .disp4(b4), .disp5(b5));

    assign disp_a = {a5, a4, a3, a2, a1, a0};
    assign disp_b = {b5, b4, b3, b2, b1, b0};

    function automatic logic [6:0] seg(input int d);
        logic [6:0] t [10];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return t[d];
    endfunction

    function automatic logic [41:0] pat(input int v);
        logic [41:0] p;
        int x;
        x = v;
        for (int i = 0; i < 6; i++) begin
            p[i*7 +: 7] = seg(x % 10);
            x = x / 10;
        end
        return p;
    endfunction

    // Reading shown after the most recently closed window, or 0 before any window closes.
    function automatic int exp_a();
        int w, n;
        w = cyc / GA;
        n = (w > 0 && ca.exists(w)) ? ca[w] : 0;
        return n > MAX_A ? MAX_A : n;
    endfunction

    function automatic int exp_b();
        int w, n;
        w = cyc / GB;
        n = (w > 0 && cb.exists(w)) ? cb[w] : 0;
        return n > MAX_B ? MAX_B : n;
    endfunction

    // Called at a falling edge; a rising input is counted on the third following posedge.
    task automatic drive(input logic a, input logic b);
        int w;
        if (a && !sig_a) begin
            w = (cyc + 2) / GA + 1;
            ca[w] = ca.exists(w) ? ca[w] + 1 : 1;
        end
        if (b && !sig_b) begin
            w = (cyc + 2) / GB + 1;
            cb[w] = cb.exists(w) ? cb[w] + 1 : 1;
        end
        sig_a = a;
        sig_b = b;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (disp_a !== pat(0) || disp_b !== pat(0)) begin
            n_fail++;
            $display("FAIL reset_hold a=%h b=%h exp=%h", disp_a, disp_b, pat(0));
        end
        rst = 1'b1;
        cyc = 0;
        for (int i = 0; i < GA; i++) begin
            drive(1'b0, 1'b0);
            if (cyc % GB == 0) begin
                n_cmp++;
                if (disp_a !== pat(0) || disp_b !== pat(0)) begin
                    n_fail++;
                    $display("FAIL idle_window cyc=%0d a=%h b=%h exp=%h", cyc, disp_a, disp_b, pat(0));
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3 * GA; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (cyc % GB == 0) begin
                n_cmp++;
                if (disp_a !== pat(exp_a())) begin
                    n_fail++;
                    $display("FAIL random_a cyc=%0d got=%h exp=%h (%0d)", cyc, disp_a, pat(exp_a()), exp_a());
                end
                n_cmp++;
                if (disp_b !== pat(exp_b())) begin
                    n_fail++;
                    $display("FAIL random_b cyc=%0d got=%h exp=%h (%0d)", cyc, disp_b, pat(exp_b()), exp_b());
                end
            end
            if (cyc % GB == GB / 2) begin
                n_cmp++;
                if (disp_a !== pat(exp_a())) begin
                    n_fail++;
                    $display("FAIL hold_a cyc=%0d got=%h exp=%h", cyc, disp_a, pat(exp_a()));
                end
            end
        end
    endtask

    task automatic test_window_edge();
        int ra, rb;
        for (int i = 0; i < 2 * GA; i++) begin
            ra = cyc % GA;
            rb = cyc % GB;
            drive(ra == 2 || ra == GA - 5 || ra == GA - 3 || ra == GA - 1,
                  rb == 2 || rb == GB - 3 || rb == GB - 1);
            if (cyc % GB == 0) begin
                n_cmp++;
                if (disp_a !== pat(exp_a())) begin
                    n_fail++;
                    $display("FAIL window_edge_a cyc=%0d got=%h exp=%h (%0d)", cyc, disp_a, pat(exp_a()), exp_a());
                end
                n_cmp++;
                if (disp_b !== pat(exp_b())) begin
                    n_fail++;
                    $display("FAIL window_edge_b cyc=%0d got=%h exp=%h (%0d)", cyc, disp_b, pat(exp_b()), exp_b());
                end
            end
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 2 * GA; i++) begin
            drive(~sig_a, ~sig_b);
            if (cyc % GB == 0) begin
                n_cmp++;
                if (disp_a !== pat(exp_a())) begin
                    n_fail++;
                    $display("FAIL dense_a cyc=%0d got=%h exp=%h (%0d)", cyc, disp_a, pat(exp_a()), exp_a());
                end
                n_cmp++;
                if (disp_b !== pat(exp_b())) begin
                    n_fail++;
                    $display("FAIL saturate_b cyc=%0d got=%h exp=%h (%0d)", cyc, disp_b, pat(exp_b()), exp_b());
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 20; i++) drive(i % 2 == 0 && i < 14, i % 2 == 0 && i < 14);
        rst = 1'b0;
        sig_a = 1'b0;
        sig_b = 1'b0;
        #1;
        n_cmp++;
        if (disp_a !== pat(0) || disp_b !== pat(0)) begin
            n_fail++;
            $display("FAIL mid_reset a=%h b=%h exp=%h", disp_a, disp_b, pat(0));
        end
        @(posedge clk);
        @(negedge clk);
        ca.delete();
        cb.delete();
        cyc = 0;
        rst = 1'b1;
        for (int i = 0; i < GA; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (cyc % GB == 0 || cyc == GB - 1) begin
                n_cmp++;
                if (disp_a !== pat(exp_a()) || disp_b !== pat(exp_b())) begin
                    n_fail++;
                    $display("FAIL post_reset cyc=%0d a=%h b=%h exp_a=%0d exp_b=%0d", cyc, disp_a, disp_b, exp_a(), exp_b());
                end
            end
        end
    endtask

    task automatic test_constant();
        for (int i = 0; i < 2 * GA; i++) begin
            drive(1'b1, 1'b1);
            if (cyc % GB == 0) begin
                n_cmp++;
                if (disp_a !== pat(exp_a()) || disp_b !== pat(exp_b())) begin
                    n_fail++;
                    $display("FAIL constant cyc=%0d a=%h b=%h exp_a=%0d exp_b=%0d", cyc, disp_a, disp_b, exp_a(), exp_b());
                end
            end
        end
        n_cmp++;
        if (disp_a !== pat(0) || disp_b !== pat(0)) begin
            n_fail++;
            $display("FAIL constant_zero a=%h b=%h exp=%h", disp_a, disp_b, pat(0));
        end
    endtask

    initial begin
        test_reset();
        test_random();
        test_window_edge();
        test_saturation();
        test_mid_reset();
        test_constant();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
